// File: rtl/ni_endpoint.sv
// Network-interface endpoint: host TX FIFO toward node A, node B RX FIFO toward host.
// Optional misroute checker on the RX path is enabled by defining NI_RX_CHECK_EN.
module ni_endpoint #(
  parameter int unsigned HP    = 0,
  parameter int unsigned VP    = 0,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_tx_vld,
  output logic        host_tx_rdy,
  input  logic        host_tx_qos,
  input  logic [1:0]  host_tx_type,
  input  logic [5:0]  host_tx_tgt,
  input  logic [7:0]  host_tx_data,
  output logic        pkt_in_vld,
  input  logic        pkt_in_rdy,
  output logic        pkt_in_qos,
  output logic [1:0]  pkt_in_type,
  output logic [5:0]  pkt_in_src,
  output logic [5:0]  pkt_in_tgt,
  output logic [7:0]  pkt_in_data,
  input  logic        pkt_out_vld,
  output logic        pkt_out_rdy,
  input  logic        pkt_out_qos,
  input  logic [1:0]  pkt_out_type,
  input  logic [5:0]  pkt_out_src,
  input  logic [5:0]  pkt_out_tgt,
  input  logic [7:0]  pkt_out_data,
  output logic        host_rx_vld,
  input  logic        host_rx_rdy,
  output logic [22:0] host_rx_pkt,
  output logic [15:0] tx_cnt,
  output logic [15:0] rx_cnt,
  input  logic        err_clr,
  output logic        misroute_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 17;
  localparam int unsigned RW = 23;
  localparam logic [5:0]    LOC  = {3'(VP), 3'(HP)};
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // The source field of every TX entry is the constant local coordinate, so it is not stored.
  logic [TW-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q;
  logic [CW-1:0] tx_occ_q, tx_occ_d;
  logic          tx_rdy_q, tx_vld_q;
  logic [15:0]   tx_cnt_q;
  logic          tx_push, tx_pop;
  logic [TW-1:0] tx_head;

  assign tx_push = host_tx_vld && tx_rdy_q;
  assign tx_pop  = tx_vld_q && pkt_in_rdy;

  always_comb begin
    tx_occ_d = tx_occ_q;
    if (tx_push && !tx_pop)      tx_occ_d = tx_occ_q + CW'(1);
    else if (!tx_push && tx_pop) tx_occ_d = tx_occ_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_occ_q <= '0;
      tx_rdy_q <= 1'b0;
      tx_vld_q <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop) begin
        tx_rd_q  <= tx_rd_q + AW'(1);
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
      tx_occ_q <= tx_occ_d;
      tx_rdy_q <= (tx_occ_d != FULL);
      tx_vld_q <= (tx_occ_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= {host_tx_qos, host_tx_type, host_tx_tgt, host_tx_data};
  end

  assign tx_head     = tx_mem_q[tx_rd_q];
  assign pkt_in_vld  = tx_vld_q;
  assign host_tx_rdy = tx_rdy_q;
  assign pkt_in_src  = LOC;
  assign {pkt_in_qos, pkt_in_type, pkt_in_tgt, pkt_in_data} = tx_head;
  assign tx_cnt      = tx_cnt_q;

  // RX path mirrors TX but stores the full received packet.
  logic [RW-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q;
  logic [CW-1:0] rx_occ_q, rx_occ_d;
  logic          rx_rdy_q, rx_vld_q;
  logic [15:0]   rx_cnt_q;
  logic          rx_push, rx_pop;

  assign rx_push = pkt_out_vld && rx_rdy_q;
  assign rx_pop  = rx_vld_q && host_rx_rdy;

  always_comb begin
    rx_occ_d = rx_occ_q;
    if (rx_push && !rx_pop)      rx_occ_d = rx_occ_q + CW'(1);
    else if (!rx_push && rx_pop) rx_occ_d = rx_occ_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_occ_q <= '0;
      rx_rdy_q <= 1'b0;
      rx_vld_q <= 1'b0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_q  <= rx_wr_q + AW'(1);
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
      rx_occ_q <= rx_occ_d;
      rx_rdy_q <= (rx_occ_d != FULL);
      rx_vld_q <= (rx_occ_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= {pkt_out_qos, pkt_out_type, pkt_out_src, pkt_out_tgt, pkt_out_data};
  end

  assign host_rx_vld = rx_vld_q;
  assign pkt_out_rdy = rx_rdy_q;
  assign host_rx_pkt = rx_mem_q[rx_rd_q];
  assign rx_cnt      = rx_cnt_q;

`ifdef NI_RX_CHECK_EN
  // Sticky flag for unicast packets delivered to the wrong node; a new set beats a clear.
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (rx_push && (pkt_out_type == 2'd0) && (pkt_out_tgt != LOC)) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign misroute_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign misroute_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ni_endpoint.sv
// Bench for ni_endpoint (HP=2, VP=5, DEPTH=4): queue-level model checked every cycle plus directed literals.
module tb_ni_endpoint;
  localparam int unsigned DEPTH = 4;
  localparam logic [5:0]  LOC   = 6'h2A;
`ifdef NI_RX_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_tx_vld = 1'b0, host_tx_qos = 1'b0;
  logic [1:0]  host_tx_type = 2'd0;
  logic [5:0]  host_tx_tgt = 6'd0;
  logic [7:0]  host_tx_data = 8'd0;
  logic        host_tx_rdy;
  logic        pkt_in_vld, pkt_in_qos;
  logic        pkt_in_rdy = 1'b0;
  logic [1:0]  pkt_in_type;
  logic [5:0]  pkt_in_src, pkt_in_tgt;
  logic [7:0]  pkt_in_data;
  logic        pkt_out_vld = 1'b0, pkt_out_qos = 1'b0;
  logic [1:0]  pkt_out_type = 2'd0;
  logic [5:0]  pkt_out_src = 6'd0, pkt_out_tgt = 6'd0;
  logic [7:0]  pkt_out_data = 8'd0;
  logic        pkt_out_rdy;
  logic        host_rx_vld;
  logic        host_rx_rdy = 1'b0;
  logic [22:0] host_rx_pkt;
  logic [15:0] tx_cnt, rx_cnt;
  logic        err_clr = 1'b0;
  logic        misroute_err;

  int n_cmp  = 0;
  int n_fail = 0;

  ni_endpoint #(.HP(2), .VP(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .host_tx_vld(host_tx_vld), .host_tx_rdy(host_tx_rdy), .host_tx_qos(host_tx_qos),
    .host_tx_type(host_tx_type), .host_tx_tgt(host_tx_tgt), .host_tx_data(host_tx_data),
    .pkt_in_vld(pkt_in_vld), .pkt_in_rdy(pkt_in_rdy), .pkt_in_qos(pkt_in_qos),
    .pkt_in_type(pkt_in_type), .pkt_in_src(pkt_in_src), .pkt_in_tgt(pkt_in_tgt),
    .pkt_in_data(pkt_in_data),
    .pkt_out_vld(pkt_out_vld), .pkt_out_rdy(pkt_out_rdy), .pkt_out_qos(pkt_out_qos),
    .pkt_out_type(pkt_out_type), .pkt_out_src(pkt_out_src), .pkt_out_tgt(pkt_out_tgt),
    .pkt_out_data(pkt_out_data),
    .host_rx_vld(host_rx_vld), .host_rx_rdy(host_rx_rdy), .host_rx_pkt(host_rx_pkt),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_clr(err_clr), .misroute_err(misroute_err)
  );

  always #5 clk = ~clk;

  // Model: two packet queues, two counters, a sticky flag and an "out of reset" marker.
  logic [22:0] q_tx[$];
  logic [22:0] q_rx[$];
  logic [15:0] m_tx_cnt = 16'd0;
  logic [15:0] m_rx_cnt = 16'd0;
  logic        m_err    = 1'b0;
  logic        m_alive  = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    bit tpush, tpop, rpush, rpop;
    if (rst) begin
      q_tx.delete();
      q_rx.delete();
      m_tx_cnt = 16'd0;
      m_rx_cnt = 16'd0;
      m_err    = 1'b0;
      m_alive  = 1'b0;
    end else begin
      tpush = host_tx_vld && m_alive && (q_tx.size() < int'(DEPTH));
      tpop  = (q_tx.size() > 0) && pkt_in_rdy;
      rpush = pkt_out_vld && m_alive && (q_rx.size() < int'(DEPTH));
      rpop  = (q_rx.size() > 0) && host_rx_rdy;
      if (CHK_EN && rpush && pkt_out_type == 2'd0 && pkt_out_tgt != LOC) m_err = 1'b1;
      else if (CHK_EN && err_clr) m_err = 1'b0;
      if (tpop) begin
        void'(q_tx.pop_front());
        m_tx_cnt = m_tx_cnt + 16'd1;
      end
      if (tpush) q_tx.push_back({host_tx_qos, host_tx_type, LOC, host_tx_tgt, host_tx_data});
      if (rpop) void'(q_rx.pop_front());
      if (rpush) begin
        q_rx.push_back({pkt_out_qos, pkt_out_type, pkt_out_src, pkt_out_tgt, pkt_out_data});
        m_rx_cnt = m_rx_cnt + 16'd1;
      end
      m_alive = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    chk("host_tx_rdy",  32'(host_tx_rdy), 32'(m_alive && (q_tx.size() < int'(DEPTH))));
    chk("pkt_out_rdy",  32'(pkt_out_rdy), 32'(m_alive && (q_rx.size() < int'(DEPTH))));
    chk("pkt_in_vld",   32'(pkt_in_vld),  32'(q_tx.size() > 0));
    chk("host_rx_vld",  32'(host_rx_vld), 32'(q_rx.size() > 0));
    chk("tx_cnt",       32'(tx_cnt),      32'(m_tx_cnt));
    chk("rx_cnt",       32'(rx_cnt),      32'(m_rx_cnt));
    chk("misroute_err", 32'(misroute_err), 32'(m_err));
    if (q_tx.size() > 0)
      chk("pkt_in_head", 32'({pkt_in_qos, pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data}), 32'(q_tx[0]));
    if (q_rx.size() > 0)
      chk("host_rx_head", 32'(host_rx_pkt), 32'(q_rx[0]));
  endtask

  // Compare at the falling edge, then return just after the next rising edge to drive inputs.
  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] ty, input logic [5:0] tg, input logic [7:0] d);
    pkt_out_vld  = 1'b1;
    pkt_out_qos  = d[0];
    pkt_out_type = ty;
    pkt_out_src  = 6'h09;
    pkt_out_tgt  = tg;
    pkt_out_data = d;
  endtask

  initial begin
    int nxt, got, guard;
    step();
    step();
    chk("rst_tx_rdy", 32'(host_tx_rdy), 32'd0);
    chk("rst_rx_rdy", 32'(pkt_out_rdy), 32'd0);
    chk("rst_tx_cnt", 32'(tx_cnt), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_tx_rdy", 32'(host_tx_rdy), 32'd1);
    chk("post_rst_rx_rdy", 32'(pkt_out_rdy), 32'd1);

    // Single unicast injection with the node ready.
    pkt_in_rdy   = 1'b1;
    host_tx_vld  = 1'b1;
    host_tx_tgt  = 6'h3F;
    host_tx_data = 8'hA5;
    step();
    host_tx_vld = 1'b0;
    chk("lat_vld", 32'(pkt_in_vld), 32'd1);
    chk("lat_src", 32'(pkt_in_src), 32'h2A);
    chk("lat_tgt", 32'(pkt_in_tgt), 32'h3F);
    chk("lat_data", 32'(pkt_in_data), 32'hA5);
    step();
    chk("lat_tx_cnt", 32'(tx_cnt), 32'd1);
    chk("lat_drained", 32'(pkt_in_vld), 32'd0);

    // Fill TX while the node stalls, then drain in order.
    pkt_in_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_tx_vld  = 1'b1;
      host_tx_type = 2'(i);
      host_tx_tgt  = 6'(i);
      host_tx_data = 8'h10 + 8'(i);
      if (i == 4) chk("tx_full_rdy", 32'(host_tx_rdy), 32'd0);
      step();
    end
    host_tx_vld = 1'b0;
    step();
    step();
    chk("tx_hold_vld", 32'(pkt_in_vld), 32'd1);
    chk("tx_hold_data", 32'(pkt_in_data), 32'h10);
    pkt_in_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_order", 32'(pkt_in_data), 32'h10 + 32'(i));
      step();
    end
    chk("tx_empty", 32'(pkt_in_vld), 32'd0);
    chk("tx_cnt5", 32'(tx_cnt), 32'd5);

    // Fill RX while the host stalls, then release with two more beats pending.
    for (int i = 0; i < 4; i++) begin
      beat(2'd1, LOC, 8'h60 + 8'(i));
      step();
    end
    chk("rx_full_rdy", 32'(pkt_out_rdy), 32'd0);
    chk("rx_cnt4", 32'(rx_cnt), 32'd4);
    host_rx_rdy = 1'b1;
    nxt = 4;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (nxt < 6) beat(2'd1, LOC, 8'h60 + 8'(nxt));
      else pkt_out_vld = 1'b0;
      if (host_rx_vld) begin
        chk("rx_order", 32'(host_rx_pkt[7:0]), 32'h60 + 32'(got));
        got++;
      end
      if (pkt_out_vld && pkt_out_rdy) nxt++;
      step();
    end
    pkt_out_vld = 1'b0;
    chk("rx_delivered", 32'(got), 32'd6);
    chk("rx_cnt6", 32'(rx_cnt), 32'd6);

    // Misroute checker: correct target, wrong target, set-vs-clear, clear alone.
    beat(2'd0, LOC, 8'h01);
    step();
    pkt_out_vld = 1'b0;
    step();
    chk("err_good_tgt", 32'(misroute_err), 32'd0);
    beat(2'd0, 6'h11, 8'h02);
    step();
    pkt_out_vld = 1'b0;
    chk("err_set", 32'(misroute_err), 32'(CHK_EN));
    beat(2'd0, 6'h11, 8'h03);
    err_clr = 1'b1;
    step();
    pkt_out_vld = 1'b0;
    err_clr     = 1'b0;
    chk("err_set_wins", 32'(misroute_err), 32'(CHK_EN));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", 32'(misroute_err), 32'd0);
    step();

    // Reset with three entries in each FIFO.
    pkt_in_rdy  = 1'b0;
    host_rx_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_tx_vld  = 1'b1;
      host_tx_data = 8'hC0 + 8'(i);
      beat(2'd1, LOC, 8'hD0 + 8'(i));
      step();
    end
    host_tx_vld = 1'b0;
    pkt_out_vld = 1'b0;
    chk("pre_rst_tx_vld", 32'(pkt_in_vld), 32'd1);
    chk("pre_rst_rx_vld", 32'(host_rx_vld), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_tx_vld", 32'(pkt_in_vld), 32'd0);
    chk("async_rx_vld", 32'(host_rx_vld), 32'd0);
    chk("async_tx_rdy", 32'(host_tx_rdy), 32'd0);
    step();
    step();
    rst         = 1'b0;
    pkt_in_rdy  = 1'b1;
    host_rx_rdy = 1'b1;
    step();
    chk("rel_tx_rdy", 32'(host_tx_rdy), 32'd1);
    chk("rel_rx_rdy", 32'(pkt_out_rdy), 32'd1);
    chk("rel_tx_cnt", 32'(tx_cnt), 32'd0);
    chk("rel_rx_cnt", 32'(rx_cnt), 32'd0);
    step();
    chk("rel_no_stale_tx", 32'(pkt_in_vld), 32'd0);
    chk("rel_no_stale_rx", 32'(host_rx_vld), 32'd0);

    // Stream TX traffic until tx_cnt reaches 0xFFFF, then one more handshake wraps it.
    host_tx_vld  = 1'b1;
    host_tx_tgt  = 6'h05;
    host_tx_data = 8'h77;
    guard = 0;
    while (m_tx_cnt != 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    pkt_in_rdy  = 1'b0;
    host_tx_vld = 1'b0;
    chk("tx_cnt_ffff", 32'(tx_cnt), 32'hFFFF);
    step();
    chk("tx_cnt_hold", 32'(tx_cnt), 32'hFFFF);
    pkt_in_rdy = 1'b1;
    step();
    chk("tx_cnt_wrap", 32'(tx_cnt), 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
